// File: rtl/oven_timer_if.sv
// Keypad, magnetron-enable and time/done signals between oven control and the countdown timer.
// No latency of its own; it only bundles wires.
// No backpressure: every signal is a level or a one-cycle strobe.
interface oven_timer_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_clear;
  logic       key_add_min;
  logic       mag_on;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;

  // Control side: drives keys and magnetron enable, observes the time.
  modport master (
    output key_valid, key_digit, key_clear, key_add_min, mag_on,
    input  min_tens, min_ones, sec_tens, sec_ones, timer_done
  );

  // Timer side: consumes keys and magnetron enable, presents the time.
  modport slave (
    input  key_valid, key_digit, key_clear, key_add_min, mag_on,
    output min_tens, min_ones, sec_tens, sec_ones, timer_done
  );
endinterface

// File: rtl/oven_timer.sv
// BCD mm:ss countdown timer with keypad entry; counts down one second per TICK_DIV cycles while mag_on.
// Entry/clear/add land on the qualifying edge; timer_done is registered alongside the digits.
// No backpressure: keys are strobes, ignored (except +1 min) while the magnetron runs.
// Optional "+1 minute" key is built only when TIMER_ADD_MIN_EN is defined.
module oven_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       clrn,
  oven_timer_if.slave tif
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PSC_LAST = PW'(TICK_DIV - 1);

  // Time packed as {min_tens, min_ones, sec_tens, sec_ones}.
  logic [15:0]   time_q, time_n;
  logic [PW-1:0] psc_q, psc_n;
  logic          done_q;

  logic          time_zero;
  logic          digit_ok;
  logic          at_tick;
  logic          add_ok;
  logic [15:0]   time_add;

  // One second off a nonzero BCD time; seconds tens borrows to 5 so mm:ss stays sane.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign time_zero = (time_q == 16'h0000);
  assign digit_ok  = tif.key_valid && (tif.key_digit <= 4'd9);
  assign at_tick   = (psc_q == PSC_LAST);

`ifdef TIMER_ADD_MIN_EN
  // +1 minute with carry into min_tens; 99 minutes saturates by suppressing the add.
  always_comb begin
    add_ok   = tif.key_add_min && !(time_q[15:12] == 4'd9 && time_q[11:8] == 4'd9);
    time_add = time_q;
    if (time_q[11:8] == 4'd9) begin
      time_add[11:8]  = 4'd0;
      time_add[15:12] = time_q[15:12] + 4'd1;
    end else begin
      time_add[11:8]  = time_q[11:8] + 4'd1;
    end
  end
`else
  logic unused_add_min;
  assign unused_add_min = tif.key_add_min;
  assign add_ok         = 1'b0;
  assign time_add       = time_q;
`endif

  // Next time and prescaler: keys only while stopped, countdown only while running.
  always_comb begin
    time_n = time_q;
    psc_n  = psc_q;
    if (!tif.mag_on) begin
      if (tif.key_clear) begin
        time_n = 16'h0000;
        psc_n  = '0;
      end else if (digit_ok) begin
        time_n = {time_q[11:0], tif.key_digit};
        psc_n  = '0;
      end else if (add_ok) begin
        time_n = time_add;
      end
    end else if (time_zero) begin
      // Expired: prescaler parked at 0, time floors at 00:00.
      psc_n = '0;
      if (add_ok) time_n = time_add;
    end else if (at_tick) begin
      // An add on a tick wins; the prescaler holds so the decrement lands next cycle.
      if (add_ok) begin
        time_n = time_add;
      end else begin
        time_n = bcd_dec(time_q);
        psc_n  = '0;
      end
    end else begin
      psc_n = psc_q + PW'(1);
      if (add_ok) time_n = time_add;
    end
  end

  // State registers; done tracks the value being written so it never lags the digits.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      time_q <= 16'h0000;
      psc_q  <= '0;
      done_q <= 1'b1;
    end else begin
      time_q <= time_n;
      psc_q  <= psc_n;
      done_q <= (time_n == 16'h0000);
    end
  end

  assign tif.min_tens   = time_q[15:12];
  assign tif.min_ones   = time_q[11:8];
  assign tif.sec_tens   = time_q[7:4];
  assign tif.sec_ones   = time_q[3:0];
  assign tif.timer_done = done_q;

endmodule

// File: tb/tb_oven_timer.sv
// Directed bench for oven_timer with TICK_DIV=4: stimulus queues expected mm:ss/done per cycle,
// a negedge monitor pops and compares whenever an expectation falls due.
// Add-minute vectors follow TIMER_ADD_MIN_EN.
module tb_oven_timer;

  typedef struct {
    int          cyc;
    logic [15:0] t;
    logic        d;
    string       nm;
  } exp_t;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   cyc  = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e;
  logic [15:0] got;
  logic [15:0] now_t;

  oven_timer_if tif();

  oven_timer #(.TICK_DIV(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .tif  (tif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due at this cycle; a stale one is a miss.
  always @(negedge clk) begin
    got = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc || got !== e.t || tif.timer_done !== e.d) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d due=%0d got time=%h done=%b want time=%h done=%b",
                 e.nm, cyc, e.cyc, got, tif.timer_done, e.t, e.d);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic [15:0] t, input logic d, input string nm);
    exp_t x;
    x.cyc = c; x.t = t; x.d = d; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic press(input logic [3:0] dg, input logic [15:0] t, input logic d, input string nm);
    expect_at(cyc + 1, t, d, nm);
    tif.key_valid = 1'b1;
    tif.key_digit = dg;
    step(1);
    tif.key_valid = 1'b0;
  endtask

  task automatic clr(input logic [15:0] t, input logic d, input string nm);
    expect_at(cyc + 1, t, d, nm);
    tif.key_clear = 1'b1;
    step(1);
    tif.key_clear = 1'b0;
  endtask

  task automatic add_strobe(input logic [15:0] t, input logic d, input string nm);
    expect_at(cyc + 1, t, d, nm);
    tif.key_add_min = 1'b1;
    step(1);
    tif.key_add_min = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tif.key_valid   = 1'b0;
    tif.key_digit   = 4'd0;
    tif.key_clear   = 1'b0;
    tif.key_add_min = 1'b0;
    tif.mag_on      = 1'b0;

    // Reset state
    step(2);
    expect_at(cyc, 16'h0000, 1'b1, "reset");
    step(1);
    clrn = 1'b1;

    // Digit entry, done falls on first nonzero digit, invalid digit ignored
    press(4'd0,  16'h0000, 1'b1, "entry0");
    press(4'd1,  16'h0001, 1'b0, "entry1");
    press(4'd3,  16'h0013, 1'b0, "entry3");
    press(4'd0,  16'h0130, 1'b0, "entry0b");
    press(4'd12, 16'h0130, 1'b0, "bad_digit");

    // Clear beats digit in the same cycle
    expect_at(cyc + 1, 16'h0000, 1'b1, "clr_prio");
    tif.key_clear = 1'b1; tif.key_valid = 1'b1; tif.key_digit = 4'd7;
    step(1);
    tif.key_clear = 1'b0; tif.key_valid = 1'b0;
    now_t = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    checks = checks + 1;
    if (now_t !== 16'h0000 || tif.timer_done !== 1'b1) begin
        failures = failures + 1;
        $display("FAIL clr_prio_now cyc=%0d got time=%h done=%b want time=0000 done=1",
                 cyc, now_t, tif.timer_done);
    end

    // Minute borrow 01:00 -> 00:59 -> 00:58
    press(4'd1, 16'h0001, 1'b0, "ld_b1");
    press(4'd0, 16'h0010, 1'b0, "ld_b2");
    press(4'd0, 16'h0100, 1'b0, "ld_b3");
    c0 = cyc;
    expect_at(c0 + 3, 16'h0100, 1'b0, "borrow_pre");
    expect_at(c0 + 4, 16'h0059, 1'b0, "borrow1");
    expect_at(c0 + 8, 16'h0058, 1'b0, "borrow2");
    tif.mag_on = 1'b1;
    step(8);
    now_t = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    checks = checks + 1;
    if (now_t !== 16'h0058 || tif.timer_done !== 1'b0) begin
        failures = failures + 1;
        $display("FAIL borrow_now cyc=%0d got time=%h done=%b want time=0058 done=0",
                 cyc, now_t, tif.timer_done);
    end
    tif.mag_on = 1'b0;

    // Expiry and floor
    clr(16'h0000, 1'b1, "clr_exp");
    press(4'd2, 16'h0002, 1'b0, "ld_exp");
    c0 = cyc;
    expect_at(c0 + 4,  16'h0001, 1'b0, "exp_1");
    expect_at(c0 + 7,  16'h0001, 1'b0, "exp_pre");
    expect_at(c0 + 8,  16'h0000, 1'b1, "exp_done");
    expect_at(c0 + 28, 16'h0000, 1'b1, "exp_floor");
    tif.mag_on = 1'b1;
    step(28);
    now_t = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    checks = checks + 1;
    if (now_t !== 16'h0000 || tif.timer_done !== 1'b1) begin
        failures = failures + 1;
        $display("FAIL floor_now cyc=%0d got time=%h done=%b want time=0000 done=1",
                 cyc, now_t, tif.timer_done);
    end
    tif.mag_on = 1'b0;

    // Pause/resume keeps the partial second; keys ignored while running
    press(4'd5, 16'h0005, 1'b0, "ld_pause");
    c0 = cyc;
    tif.mag_on = 1'b1;
    step(2);
    tif.mag_on = 1'b0;
    step(10);
    tif.mag_on = 1'b1;
    expect_at(c0 + 13, 16'h0005, 1'b0, "resume_pre");
    expect_at(c0 + 14, 16'h0004, 1'b0, "resume_dec");
    step(2);
    press(4'd9, 16'h0004, 1'b0, "key_running");
    clr(16'h0004, 1'b0, "clr_running");

    // Asynchronous reset mid-count; no resume afterwards
    step(1);
    clrn = 1'b0;
    expect_at(cyc, 16'h0000, 1'b1, "rst_mid");
    step(1);
    clrn = 1'b1;
    expect_at(cyc + 6, 16'h0000, 1'b1, "no_resume");
    step(6);
    now_t = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
    checks = checks + 1;
    if (now_t !== 16'h0000 || tif.timer_done !== 1'b1) begin
        failures = failures + 1;
        $display("FAIL no_resume_now cyc=%0d got time=%h done=%b want time=0000 done=1",
                 cyc, now_t, tif.timer_done);
    end
    tif.mag_on = 1'b0;

`ifdef TIMER_ADD_MIN_EN
    // Add while running, off-tick
    press(4'd3, 16'h0003, 1'b0, "ld_add1");
    press(4'd0, 16'h0030, 1'b0, "ld_add2");
    c0 = cyc;
    tif.mag_on = 1'b1;
    step(1);
    add_strobe(16'h0130, 1'b0, "add_run");
    expect_at(c0 + 4, 16'h0129, 1'b0, "add_run_dec");
    step(2);
    tif.mag_on = 1'b0;

    // Add coinciding with a tick defers the decrement one cycle
    clr(16'h0000, 1'b1, "clr_add");
    press(4'd3, 16'h0003, 1'b0, "ld_add3");
    press(4'd0, 16'h0030, 1'b0, "ld_add4");
    c0 = cyc;
    tif.mag_on = 1'b1;
    step(3);
    add_strobe(16'h0130, 1'b0, "add_tick");
    expect_at(c0 + 5, 16'h0129, 1'b0, "add_tick_dec");
    expect_at(c0 + 9, 16'h0128, 1'b0, "add_tick_next");
    step(5);
    tif.mag_on = 1'b0;

    // Carry into min_tens, then saturation at 99 minutes
    clr(16'h0000, 1'b1, "clr_carry");
    press(4'd9, 16'h0009, 1'b0, "ld_c1");
    press(4'd3, 16'h0093, 1'b0, "ld_c2");
    press(4'd0, 16'h0930, 1'b0, "ld_c3");
    add_strobe(16'h1030, 1'b0, "add_carry");
    clr(16'h0000, 1'b1, "clr_sat");
    press(4'd9, 16'h0009, 1'b0, "ld_s1");
    press(4'd9, 16'h0099, 1'b0, "ld_s2");
    press(4'd1, 16'h0991, 1'b0, "ld_s3");
    press(4'd0, 16'h9910, 1'b0, "ld_s4");
    add_strobe(16'h9910, 1'b0, "add_sat");
`else
    // Without the feature the strobe does nothing
    press(4'd3, 16'h0003, 1'b0, "ld_add1");
    press(4'd0, 16'h0030, 1'b0, "ld_add2");
    add_strobe(16'h0030, 1'b0, "add_off");
    tif.mag_on = 1'b1;
    add_strobe(16'h0030, 1'b0, "add_off_run");
    tif.mag_on = 1'b0;
`endif

    step(3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s never checked due=%0d want time=%h done=%b", e.nm, e.cyc, e.t, e.d);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
